// File: rtl/rmii_rx_fcs.sv
// RMII receive front end: dibit deserialiser, preamble/SFD strip, CRC-32 and
// length checking, byte FIFO write path, and gray-coded per-cause frame counters.
module rmii_rx_fcs #(
    parameter int COUNT_W   = 16,
    parameter int MIN_LEN   = 64,
    parameter int MAX_LEN   = 1522,
    parameter bit CHECK_FCS = 1'b1
) (
    input  logic               REF_CLK,
    input  logic               arst_n,
    input  logic               CRS_DV,
    input  logic               RXD0,
    input  logic               RXD1,
    input  logic               speed_10,
    input  logic               fifo_afull,
    output logic [7:0]         fifo_din,
    output logic               fifo_wren,
    output logic               fifo_EOD_in,
    output logic               fifo_err_in,
    output logic [COUNT_W-1:0] succ_rx_count_gray,
    output logic [COUNT_W-1:0] buff_OF_count_gray,
    output logic [COUNT_W-1:0] crc_err_count_gray,
    output logic [COUNT_W-1:0] len_err_count_gray
);

    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [10:0] LEN_SAT     = 11'd2047;

    typedef enum logic [2:0] {S_IDLE, S_PREAMBLE, S_BODY, S_DROP, S_END} state_t;
    typedef enum logic [1:0] {C_OK, C_CRC, C_LEN, C_OVF} cause_t;

    // Reflected CRC-32 advanced over one byte, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    state_t               r_state, w_state_next;
    cause_t               r_cause, w_cause_d;
    logic                 r_crs_dv, r_speed10, r_skip;
    logic [1:0]           r_rxd, r_dibit;
    logic [3:0]           r_div;
    logic [7:0]           r_seq;
    logic [10:0]          r_len, w_len_next;
    logic [31:0]          r_crc, w_crc_next;
    logic [COUNT_W-1:0]   r_succ, r_bof, r_crcerr, r_lenerr;
    logic                 w_dv, w_sample_en, w_crc_bad, w_runt, w_oversize;
    logic                 w_start, w_byte, w_cause_we, w_idle_ovf;
    logic                 w_wren, w_eod, w_err;
    logic [7:0]           w_din;

    // DV also covers the cycle after CRS_DV drops, absorbing end-of-frame toggling.
    assign w_dv        = CRS_DV | r_crs_dv;
    assign w_sample_en = !r_speed10 || (r_div == 4'd5);
    assign w_crc_next  = crc32_byte(r_crc, r_seq);
    assign w_crc_bad   = CHECK_FCS && (w_crc_next != CRC_RESIDUE);
    assign w_len_next  = (r_len == LEN_SAT) ? r_len : r_len + 11'd1;
    assign w_runt      = (w_len_next < 11'(MIN_LEN));
    assign w_oversize  = (r_len == 11'(MAX_LEN));

    // State register.
    always_ff @(posedge REF_CLK) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!arst_n) r_state <= S_IDLE;
        else         r_state <= w_state_next;
    end

    // Next-state decode and FIFO write outputs, one strobe per completed byte.
    always_comb begin
        // NOTE: every signal gets a default first so no latch is inferred.
        w_state_next = r_state;
        w_wren       = 1'b0;
        w_din        = 8'h00;
        w_eod        = 1'b0;
        w_err        = 1'b0;
        w_start      = 1'b0;
        w_byte       = 1'b0;
        w_cause_we   = 1'b0;
        w_cause_d    = C_OK;
        w_idle_ovf   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (CRS_DV && !r_skip) begin
                    if (fifo_afull) w_idle_ovf   = 1'b1;
                    else            w_state_next = S_PREAMBLE;
                end
            end
            S_PREAMBLE: begin
                if (!w_dv) begin
                    w_state_next = S_IDLE;
                end else if (w_sample_en && r_seq == 8'hD5) begin
                    w_state_next = S_BODY;
                    w_start      = 1'b1;
                end
            end
            S_BODY: begin
                if (w_sample_en) begin
                    if (r_dibit == 2'd3) begin
                        w_wren     = 1'b1;
                        w_din      = r_seq;
                        w_byte     = 1'b1;
                        w_cause_we = 1'b1;
                        if (fifo_afull) begin
                            w_eod = 1'b1; w_err = 1'b1; w_cause_d = C_OVF;
                            w_state_next = S_DROP;
                        end else if (w_oversize) begin
                            w_eod = 1'b1; w_err = 1'b1; w_cause_d = C_LEN;
                            w_state_next = S_DROP;
                        end else if (!w_dv) begin
                            w_eod = 1'b1;
                            w_err = w_crc_bad | w_runt;
                            w_cause_d = w_runt ? C_LEN : (w_crc_bad ? C_CRC : C_OK);
                            w_state_next = S_END;
                        end
                    end else if (!w_dv) begin
                        // Carrier lost mid-byte: close the frame with a filler byte.
                        w_wren = 1'b1; w_eod = 1'b1; w_err = 1'b1;
                        w_cause_we = 1'b1; w_cause_d = C_LEN;
                        w_state_next = S_END;
                    end
                end
            end
            S_DROP:  if (!w_dv) w_state_next = S_END;
            S_END:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        // Nothing reaches the FIFO while reset is held, so a cut frame never gets an EOD.
        if (!arst_n) begin
            w_wren = 1'b0;
            w_din  = 8'h00;
            w_eod  = 1'b0;
            w_err  = 1'b0;
        end
    end

    assign fifo_wren   = w_wren;
    assign fifo_din    = w_din;
    assign fifo_EOD_in = w_eod;
    assign fifo_err_in = w_err;

    // Input registers, 10 Mb/s divider, dibit shifter, CRC and length tracking.
    always_ff @(posedge REF_CLK) begin
        if (!arst_n) begin
            r_crs_dv  <= 1'b0;
            r_rxd     <= 2'b00;
            r_div     <= 4'd0;
            r_speed10 <= 1'b0;
            r_seq     <= 8'h00;
            r_dibit   <= 2'd0;
            r_len     <= 11'd0;
            r_crc     <= 32'hFFFFFFFF;
            r_cause   <= C_OK;
            r_skip    <= 1'b0;
        end else begin
            r_crs_dv <= CRS_DV;
            r_rxd    <= {RXD1, RXD0};
            if (r_state == S_IDLE && CRS_DV) r_div <= 4'd0;
            else if (r_div == 4'd9)          r_div <= 4'd0;
            else                             r_div <= r_div + 4'd1;
            if (r_state == S_IDLE && w_state_next == S_PREAMBLE) r_speed10 <= speed_10;
            if (w_sample_en) r_seq <= {r_rxd, r_seq[7:2]};
            if (w_start)                              r_dibit <= 2'd0;
            else if (r_state == S_BODY && w_sample_en) r_dibit <= r_dibit + 2'd1;
            if (w_start) begin
                r_len <= 11'd0;
                r_crc <= 32'hFFFFFFFF;
            end else if (w_byte) begin
                r_len <= w_len_next;
                r_crc <= w_crc_next;
            end
            if (w_cause_we) r_cause <= w_cause_d;
            if (w_idle_ovf)  r_skip <= 1'b1;
            else if (!w_dv)  r_skip <= 1'b0;
        end
    end

    // Per-cause frame counters; exactly one steps per frame, at S_END.
    always_ff @(posedge REF_CLK) begin
        if (!arst_n) begin
            r_succ   <= '0;
            r_bof    <= '0;
            r_crcerr <= '0;
            r_lenerr <= '0;
        end else begin
            if (w_idle_ovf) r_bof <= r_bof + 1'b1;
            if (r_state == S_END) begin
                case (r_cause)
                    C_OVF:   r_bof    <= r_bof + 1'b1;
                    C_LEN:   r_lenerr <= r_lenerr + 1'b1;
                    C_CRC:   r_crcerr <= r_crcerr + 1'b1;
                    default: r_succ   <= r_succ + 1'b1;
                endcase
            end
        end
    end

    assign succ_rx_count_gray = r_succ   ^ (r_succ   >> 1);
    assign buff_OF_count_gray = r_bof    ^ (r_bof    >> 1);
    assign crc_err_count_gray = r_crcerr ^ (r_crcerr >> 1);
    assign len_err_count_gray = r_lenerr ^ (r_lenerr >> 1);

endmodule

// File: tb/tb_rmii_rx_fcs.sv
// Directed testbench for rmii_rx_fcs: frames are built byte by byte, sent as
// RMII dibits, and the FIFO write stream and gray counters are compared to
// hand-derived expectations.
module tb_rmii_rx_fcs;

    logic        REF_CLK = 1'b0;
    logic        arst_n, CRS_DV, RXD0, RXD1, speed_10, fifo_afull;
    logic [7:0]  fifo_din;
    logic        fifo_wren, fifo_EOD_in, fifo_err_in;
    logic [15:0] succ_rx_count_gray, buff_OF_count_gray, crc_err_count_gray, len_err_count_gray;

    typedef struct packed {logic [7:0] d; logic eod; logic err;} wr_t;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] tx[$];
    wr_t        wq[$];

    rmii_rx_fcs dut (
        .REF_CLK(REF_CLK), .arst_n(arst_n), .CRS_DV(CRS_DV), .RXD0(RXD0), .RXD1(RXD1),
        .speed_10(speed_10), .fifo_afull(fifo_afull), .fifo_din(fifo_din),
        .fifo_wren(fifo_wren), .fifo_EOD_in(fifo_EOD_in), .fifo_err_in(fifo_err_in),
        .succ_rx_count_gray(succ_rx_count_gray), .buff_OF_count_gray(buff_OF_count_gray),
        .crc_err_count_gray(crc_err_count_gray), .len_err_count_gray(len_err_count_gray)
    );

    always #10 REF_CLK = ~REF_CLK;

    // FIFO-side monitor, sampling midway between the driving edge and the capture edge.
    initial begin
        forever begin
            @(negedge REF_CLK);
            #5;
            if (fifo_wren === 1'b1) wq.push_back(wr_t'({fifo_din, fifo_EOD_in, fifo_err_in}));
        end
    end

    function automatic logic [63:0] cnts();
        return {succ_rx_count_gray, buff_OF_count_gray, crc_err_count_gray, len_err_count_gray};
    endfunction

    function automatic wr_t last_wr();
        if (wq.size() == 0) return '0;
        return wq[wq.size()-1];
    endfunction

    function automatic int data_errs(input int n);
        int m = 0;
        for (int i = 0; i < n; i++)
            if (i >= wq.size() || i >= tx.size() || wq[i].d !== tx[i]) m++;
        return m;
    endfunction

    function automatic int eods_before_last();
        int m = 0;
        for (int i = 0; i + 1 < wq.size(); i++) if (wq[i].eod) m++;
        return m;
    endfunction

    // Payload 0,1,2,... followed by the Ethernet FCS (optionally corrupted), LSB first.
    task automatic build_frame(input int n_payload, input bit bad_fcs);
        logic [31:0] crc;
        logic        fb;
        tx.delete();
        crc = 32'hFFFFFFFF;
        for (int i = 0; i < n_payload; i++) begin
            tx.push_back(8'(i));
            for (int b = 0; b < 8; b++) begin
                fb  = tx[i][b] ^ crc[0];
                crc = {1'b0, crc[31:1]};
                if (fb) crc = crc ^ 32'hEDB88320;
            end
        end
        crc = ~crc;
        if (bad_fcs) crc = crc ^ 32'h0000_0001;
        for (int k = 0; k < 4; k++) tx.push_back(crc[8*k +: 8]);
    endtask

    task automatic drive_dibit(input logic [1:0] d, input logic dv, input int hold);
        repeat (hold) begin
            @(negedge REF_CLK);
            RXD0   = d[0];
            RXD1   = d[1];
            CRS_DV = dv;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        for (int k = 0; k < 4; k++) drive_dibit(b[2*k +: 2], 1'b1, hold);
    endtask

    // Preamble, SFD, tx bytes, optional stray dibit, then an inter-packet gap.
    task automatic send_frame(input int hold, input int afull_at, input int rst_at, input bit extra);
        for (int i = 0; i < 7; i++) send_byte(8'h55, hold);
        send_byte(8'hD5, hold);
        for (int i = 0; i < tx.size(); i++) begin
            if (i == afull_at) fifo_afull = 1'b1;
            if (i == rst_at)   arst_n     = 1'b0;
            send_byte(tx[i], hold);
        end
        if (extra) drive_dibit(2'b10, 1'b1, hold);
        repeat (48) drive_dibit(2'b00, 1'b0, hold);
        fifo_afull = 1'b0;
    endtask

    task automatic test_reset;
        arst_n = 1'b0;
        repeat (3) @(negedge REF_CLK);
        #5;
        n_checks++; if (fifo_wren !== 1'b0) begin n_fail++; $display("FAIL rst_wren: got %b want 0", fifo_wren); end
        n_checks++; if (fifo_din !== 8'h00) begin n_fail++; $display("FAIL rst_din: got %h want 00", fifo_din); end
        n_checks++; if ({fifo_EOD_in, fifo_err_in} !== 2'b00) begin n_fail++; $display("FAIL rst_eod_err: got %b want 00", {fifo_EOD_in, fifo_err_in}); end
        n_checks++; if (cnts() !== 64'h0) begin n_fail++; $display("FAIL rst_counters: got %h want 0", cnts()); end
        @(negedge REF_CLK);
        arst_n = 1'b1;
        repeat (4) @(negedge REF_CLK);
    endtask

    task automatic test_good_frame;
        wr_t lw;
        build_frame(60, 1'b0); wq.delete(); send_frame(1, -1, -1, 1'b0);
        lw = last_wr();
        n_checks++; if (wq.size() !== 64) begin n_fail++; $display("FAIL good_count: got %0d want 64", wq.size()); end
        n_checks++; if (data_errs(64) !== 0) begin n_fail++; $display("FAIL good_data: got %0d bad bytes want 0", data_errs(64)); end
        n_checks++; if (eods_before_last() !== 0) begin n_fail++; $display("FAIL good_early_eod: got %0d want 0", eods_before_last()); end
        n_checks++; if ({lw.eod, lw.err} !== 2'b10) begin n_fail++; $display("FAIL good_last: got %b want 10", {lw.eod, lw.err}); end
        n_checks++; if (cnts() !== 64'h0001_0000_0000_0000) begin n_fail++; $display("FAIL good_cnt: got %h want 0001000000000000", cnts()); end
    endtask

    task automatic test_bad_fcs;
        wr_t lw;
        build_frame(60, 1'b0);
        tx[10] = tx[10] ^ 8'h01;
        wq.delete(); send_frame(1, -1, -1, 1'b0);
        lw = last_wr();
        n_checks++; if (wq.size() !== 64 || data_errs(64) !== 0) begin n_fail++; $display("FAIL crc_stream: got %0d writes %0d bad want 64/0", wq.size(), data_errs(64)); end
        n_checks++; if ({lw.eod, lw.err} !== 2'b11) begin n_fail++; $display("FAIL crc_last: got %b want 11", {lw.eod, lw.err}); end
        n_checks++; if (cnts() !== 64'h0001_0000_0001_0000) begin n_fail++; $display("FAIL crc_cnt: got %h want 0001000000010000", cnts()); end
    endtask

    task automatic test_runt;
        wr_t lw;
        build_frame(36, 1'b0); wq.delete(); send_frame(1, -1, -1, 1'b0);
        lw = last_wr();
        n_checks++; if (wq.size() !== 40 || data_errs(40) !== 0) begin n_fail++; $display("FAIL runt_stream: got %0d writes %0d bad want 40/0", wq.size(), data_errs(40)); end
        n_checks++; if ({lw.eod, lw.err} !== 2'b11) begin n_fail++; $display("FAIL runt_last: got %b want 11", {lw.eod, lw.err}); end
        n_checks++; if (cnts() !== 64'h0001_0000_0001_0001) begin n_fail++; $display("FAIL runt_cnt: got %h want 0001000000010001", cnts()); end
        build_frame(36, 1'b1); wq.delete(); send_frame(1, -1, -1, 1'b0);
        lw = last_wr();
        n_checks++; if ({lw.eod, lw.err} !== 2'b11) begin n_fail++; $display("FAIL runt_bad_last: got %b want 11", {lw.eod, lw.err}); end
        n_checks++; if (cnts() !== 64'h0001_0000_0001_0003) begin n_fail++; $display("FAIL runt_bad_cnt: got %h want 0001000000010003", cnts()); end
    endtask

    task automatic test_oversize;
        wr_t lw;
        tx.delete();
        for (int i = 0; i < 1600; i++) tx.push_back(8'(i));
        wq.delete(); send_frame(1, -1, -1, 1'b0);
        lw = last_wr();
        n_checks++; if (wq.size() !== 1523) begin n_fail++; $display("FAIL over_count: got %0d want 1523", wq.size()); end
        n_checks++; if (data_errs(1523) !== 0 || eods_before_last() !== 0) begin n_fail++; $display("FAIL over_stream: got %0d bad %0d early eod want 0/0", data_errs(1523), eods_before_last()); end
        n_checks++; if ({lw.eod, lw.err} !== 2'b11) begin n_fail++; $display("FAIL over_last: got %b want 11", {lw.eod, lw.err}); end
        n_checks++; if (cnts() !== 64'h0001_0000_0001_0002) begin n_fail++; $display("FAIL over_cnt: got %h want 0001000000010002", cnts()); end
        build_frame(60, 1'b0); wq.delete(); send_frame(1, -1, -1, 1'b0);
        lw = last_wr();
        n_checks++; if (wq.size() !== 64 || data_errs(64) !== 0 || {lw.eod, lw.err} !== 2'b10) begin n_fail++; $display("FAIL over_next: got %0d writes last %b want 64/10", wq.size(), {lw.eod, lw.err}); end
        n_checks++; if (cnts() !== 64'h0003_0000_0001_0002) begin n_fail++; $display("FAIL over_next_cnt: got %h want 0003000000010002", cnts()); end
    endtask

    task automatic test_afull;
        wr_t lw;
        build_frame(60, 1'b0); wq.delete();
        fifo_afull = 1'b1;
        send_frame(1, -1, -1, 1'b0);
        n_checks++; if (wq.size() !== 0) begin n_fail++; $display("FAIL afull_start_writes: got %0d want 0", wq.size()); end
        n_checks++; if (cnts() !== 64'h0003_0001_0001_0002) begin n_fail++; $display("FAIL afull_start_cnt: got %h want 0003000100010002", cnts()); end
        wq.delete(); send_frame(1, 20, -1, 1'b0);
        lw = last_wr();
        n_checks++; if (wq.size() !== 20 || data_errs(20) !== 0 || eods_before_last() !== 0) begin n_fail++; $display("FAIL afull_mid_stream: got %0d writes %0d bad want 20/0", wq.size(), data_errs(20)); end
        n_checks++; if ({lw.eod, lw.err} !== 2'b11) begin n_fail++; $display("FAIL afull_mid_last: got %b want 11", {lw.eod, lw.err}); end
        n_checks++; if (cnts() !== 64'h0003_0003_0001_0002) begin n_fail++; $display("FAIL afull_mid_cnt: got %h want 0003000300010002", cnts()); end
    endtask

    task automatic test_10mbps;
        wr_t lw;
        speed_10 = 1'b1;
        build_frame(60, 1'b0); wq.delete(); send_frame(10, -1, -1, 1'b0);
        speed_10 = 1'b0;
        lw = last_wr();
        n_checks++; if (wq.size() !== 64 || data_errs(64) !== 0 || eods_before_last() !== 0) begin n_fail++; $display("FAIL slow_stream: got %0d writes %0d bad want 64/0", wq.size(), data_errs(64)); end
        n_checks++; if ({lw.eod, lw.err} !== 2'b10) begin n_fail++; $display("FAIL slow_last: got %b want 10", {lw.eod, lw.err}); end
        n_checks++; if (cnts() !== 64'h0002_0003_0001_0002) begin n_fail++; $display("FAIL slow_cnt: got %h want 0002000300010002", cnts()); end
    endtask

    task automatic test_mid_reset;
        int eods;
        wr_t lw;
        build_frame(60, 1'b0); wq.delete(); send_frame(1, -1, 29, 1'b0);
        eods = 0;
        foreach (wq[i]) if (wq[i].eod) eods++;
        n_checks++; if (eods !== 0 || wq.size() >= 64) begin n_fail++; $display("FAIL mrst_eod: got %0d eods %0d writes want 0 and <64", eods, wq.size()); end
        arst_n = 1'b1;
        repeat (4) @(negedge REF_CLK);
        n_checks++; if (cnts() !== 64'h0) begin n_fail++; $display("FAIL mrst_cnt: got %h want 0", cnts()); end
        wq.delete(); send_frame(1, -1, -1, 1'b0);
        lw = last_wr();
        n_checks++; if (wq.size() !== 64 || data_errs(64) !== 0 || {lw.eod, lw.err} !== 2'b10) begin n_fail++; $display("FAIL mrst_next: got %0d writes last %b want 64/10", wq.size(), {lw.eod, lw.err}); end
        n_checks++; if (cnts() !== 64'h0001_0000_0000_0000) begin n_fail++; $display("FAIL mrst_next_cnt: got %h want 0001000000000000", cnts()); end
    endtask

    task automatic test_misalign;
        wr_t lw;
        build_frame(60, 1'b0); wq.delete(); send_frame(1, -1, -1, 1'b1);
        tx.push_back(8'h00);
        lw = last_wr();
        n_checks++; if (wq.size() !== 65 || data_errs(65) !== 0 || eods_before_last() !== 0) begin n_fail++; $display("FAIL mis_stream: got %0d writes %0d bad want 65/0", wq.size(), data_errs(65)); end
        n_checks++; if ({lw.eod, lw.err} !== 2'b11) begin n_fail++; $display("FAIL mis_last: got %b want 11", {lw.eod, lw.err}); end
        n_checks++; if (cnts() !== 64'h0001_0000_0000_0001) begin n_fail++; $display("FAIL mis_cnt: got %h want 0001000000000001", cnts()); end
    endtask

    initial begin
        arst_n     = 1'b0;
        CRS_DV     = 1'b0;
        RXD0       = 1'b0;
        RXD1       = 1'b0;
        speed_10   = 1'b0;
        fifo_afull = 1'b0;
        test_reset();
        test_good_frame();
        test_bad_fcs();
        test_runt();
        test_oversize();
        test_afull();
        test_10mbps();
        test_mid_reset();
        test_misalign();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
